// File: rtl/pcm_stream.sv
// PCM sample streamer: assembles 16-bit samples from CPU byte writes into a FIFO,
// pops one per sample-rate strobe and mixes it with the PSG sample under saturation.
module pcm_stream #(
   parameter int unsigned DEPTH_LOG2 = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr,
   input  logic        adr,
   input  logic [7:0]  data,
   input  logic        clken,
   input  logic [15:0] sound_in,
   output logic [15:0] sound_out,
   output logic        full,
   output logic        empty,
   output logic        underrun
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   cnt_t;

   logic [15:0] mem [Depth];

   ptr_t        wr_ptr_q, wr_ptr_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   cnt_t        count_q, count_d;
   logic        phase_q, phase_d;
   logic [7:0]  low_q, low_d;
   logic        underrun_q, underrun_d;
   logic [15:0] sound_out_q, sound_out_d;

   logic        byte_wr, ctl_wr, flush;
   logic        push_req, push, pop;
   logic [15:0] sample, pcm_term, mix_sat;
   logic [16:0] mix_sum;

   assign full      = (count_q == cnt_t'(Depth));
   assign empty     = (count_q == '0);
   assign underrun  = underrun_q;
   assign sound_out = sound_out_q;

   always_comb begin
      byte_wr  = wr && !adr;
      ctl_wr   = wr && adr;
      flush    = ctl_wr && data[0];
      sample   = {data, low_q};
      push_req = byte_wr && phase_q;
      // A flush in the same cycle suppresses the pop so the PCM term is silent.
      pop      = clken && !empty && !flush;
      // When full, a simultaneous pop frees the slot before the push lands.
      push     = push_req && (!full || pop);
      pcm_term = pop ? mem[rd_ptr_q] : 16'h0000;
   end

   always_comb begin
      mix_sum = {sound_in[15], sound_in} + {pcm_term[15], pcm_term};
      if (mix_sum[16] != mix_sum[15]) begin
         mix_sat = mix_sum[16] ? 16'h8000 : 16'h7FFF;
      end else begin
         mix_sat = mix_sum[15:0];
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      phase_d     = phase_q;
      low_d       = low_q;
      underrun_d  = underrun_q;
      sound_out_d = sound_out_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         phase_d  = 1'b0;
      end else begin
         if (byte_wr) begin
            if (phase_q) begin
               phase_d = 1'b0;
            end else begin
               low_d   = data;
               phase_d = 1'b1;
            end
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
         endcase
      end

      if (ctl_wr && data[1]) begin
         underrun_d = 1'b0;
      end
      if (clken && empty && !flush) begin
         underrun_d = 1'b1;
      end

      if (clken) begin
         sound_out_d = mix_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         phase_q     <= 1'b0;
         low_q       <= 8'h00;
         underrun_q  <= 1'b0;
         sound_out_q <= 16'h0000;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         phase_q     <= phase_d;
         low_q       <= low_d;
         underrun_q  <= underrun_d;
         sound_out_q <= sound_out_d;
      end
   end

   // Storage left unreset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr_q] <= sample;
      end
   end

endmodule

// File: tb/tb_pcm_stream.sv
// Bench for pcm_stream: directed scenarios plus randomized traffic checked against a
// queue-based reference model of the sample stream.
module tb_pcm_stream;

   logic        clk = 1'b0;
   logic        reset, wr, adr, clken;
   logic [7:0]  data;
   logic [15:0] sound_in, sound_out;
   logic        full, empty, underrun;

   always #5 clk = ~clk;

   pcm_stream #(.DEPTH_LOG2(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr        (wr),
      .adr       (adr),
      .data      (data),
      .clken     (clken),
      .sound_in  (sound_in),
      .sound_out (sound_out),
      .full      (full),
      .empty     (empty),
      .underrun  (underrun)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [15:0] m_q [$];
   bit          m_phase;
   logic [7:0]  m_low;
   bit          m_under;
   logic [15:0] m_out;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s[15:0];
   endfunction

   task automatic model_step(input logic r, input logic w, input logic a,
                             input logic [7:0] d, input logic ce, input logic [15:0] si);
      logic [15:0] pcm;
      bit          flush;
      if (r) begin
         m_q.delete();
         m_phase = 0;
         m_low   = 8'h00;
         m_under = 0;
         m_out   = 16'h0000;
         return;
      end
      pcm   = 16'h0000;
      flush = w && a && d[0];
      if (w && a && d[1]) m_under = 0;
      if (ce && !flush) begin
         if (m_q.size() > 0) pcm = m_q.pop_front();
         else m_under = 1;
      end
      if (w && !a) begin
         if (m_phase) begin
            if (m_q.size() < 64) m_q.push_back({d, m_low});
            m_phase = 0;
         end else begin
            m_low   = d;
            m_phase = 1;
         end
      end
      if (flush) begin
         m_q.delete();
         m_phase = 0;
      end
      if (ce) m_out = sat_add(si, pcm);
   endtask

   task automatic cyc(input logic r, input logic w, input logic a, input logic [7:0] d,
                      input logic ce, input logic [15:0] si);
      reset = r; wr = w; adr = a; data = d; clken = ce; sound_in = si;
      @(posedge clk);
      #1;
      model_step(r, w, a, d, ce, si);
      check_eq("sound_out", {16'h0, sound_out}, {16'h0, m_out});
      check_eq("empty", {31'h0, empty}, {31'h0, m_q.size() == 0});
      check_eq("full", {31'h0, full}, {31'h0, m_q.size() == 64});
      check_eq("underrun", {31'h0, underrun}, {31'h0, m_under});
      reset = 0; wr = 0; clken = 0;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 8'h00, 0, 16'h0000);
   endtask

   task automatic wbyte(input logic [7:0] d);
      cyc(0, 1, 0, d, 0, 16'h0000);
   endtask

   task automatic wctl(input logic [7:0] d);
      cyc(0, 1, 1, d, 0, 16'h0000);
   endtask

   task automatic wsample(input logic [15:0] s);
      wbyte(s[7:0]);
      wbyte(s[15:8]);
   endtask

   task automatic pop(input logic [15:0] si);
      cyc(0, 0, 0, 8'h00, 1, si);
   endtask

   function automatic logic [15:0] fill_val(input int i);
      return 16'(i * 16'h0301 + 16'h1007);
   endfunction

   initial begin
      reset = 1; wr = 0; adr = 0; data = 0; clken = 0; sound_in = 0;

      // Reset state
      cyc(1, 0, 0, 8'h00, 0, 16'h0000);
      idle();
      check_eq("rst_empty", {31'h0, empty}, 32'd1);
      check_eq("rst_full", {31'h0, full}, 32'd0);
      check_eq("rst_underrun", {31'h0, underrun}, 32'd0);
      check_eq("rst_out", {16'h0, sound_out}, 32'h0);

      // Basic byte assembly and mix
      wbyte(8'h34);
      wbyte(8'h12);
      pop(16'h0100);
      check_eq("basic_out", {16'h0, sound_out}, 32'h1334);
      check_eq("basic_empty", {31'h0, empty}, 32'd1);

      // Saturation both ways
      wsample(16'h7000);
      pop(16'h2000);
      check_eq("sat_pos", {16'h0, sound_out}, 32'h7FFF);
      wsample(16'h9000);
      pop(16'hA000);
      check_eq("sat_neg", {16'h0, sound_out}, 32'h8000);
      idle();
      check_eq("hold_out", {16'h0, sound_out}, 32'h8000);

      // Fill to full, overflow discarded, drain in order
      for (int i = 0; i < 64; i++) wsample(fill_val(i));
      check_eq("fill_full", {31'h0, full}, 32'd1);
      wsample(16'hDEAD);
      check_eq("ovf_full", {31'h0, full}, 32'd1);
      for (int i = 0; i < 64; i++) begin
         pop(16'h0000);
         check_eq("drain_val", {16'h0, sound_out}, {16'h0, fill_val(i)});
      end
      check_eq("drain_empty", {31'h0, empty}, 32'd1);
      check_eq("drain_no_under", {31'h0, underrun}, 32'd0);

      // Underrun and its clear
      pop(16'h0055);
      check_eq("under_out", {16'h0, sound_out}, 32'h0055);
      check_eq("under_set", {31'h0, underrun}, 32'd1);
      wctl(8'h02);
      check_eq("under_clr", {31'h0, underrun}, 32'd0);

      // Flush discards a pending low byte
      wbyte(8'hAA);
      wctl(8'h01);
      wbyte(8'h11);
      wbyte(8'h22);
      check_eq("flush_cnt1", {30'h0, empty, full}, 32'd0);
      pop(16'h0000);
      check_eq("flush_val", {16'h0, sound_out}, 32'h2211);
      check_eq("flush_empty", {31'h0, empty}, 32'd1);

      // Push and pop together at count 1
      wsample(16'h4321);
      wbyte(8'h65);
      cyc(0, 1, 0, 8'h87, 1, 16'h0000);
      check_eq("pp1_val", {16'h0, sound_out}, 32'h4321);
      check_eq("pp1_cnt", {31'h0, empty}, 32'd0);
      pop(16'h0000);
      check_eq("pp1_next", {16'h0, sound_out}, 32'h8765);
      check_eq("pp1_empty", {31'h0, empty}, 32'd1);

      // Push and pop together when full
      for (int i = 0; i < 64; i++) wsample(fill_val(i + 5));
      wbyte(8'hCD);
      cyc(0, 1, 0, 8'hAB, 1, 16'h0000);
      check_eq("ppf_val", {16'h0, sound_out}, {16'h0, fill_val(5)});
      check_eq("ppf_full", {31'h0, full}, 32'd1);
      for (int i = 1; i < 64; i++) begin
         pop(16'h0000);
         check_eq("ppf_drain", {16'h0, sound_out}, {16'h0, fill_val(i + 5)});
      end
      pop(16'h0000);
      check_eq("ppf_last", {16'h0, sound_out}, 32'hABCD);

      // Flush coincident with clken
      wsample(16'h1111);
      cyc(0, 1, 1, 8'h01, 1, 16'h0033);
      check_eq("fc_out", {16'h0, sound_out}, 32'h0033);
      check_eq("fc_under", {31'h0, underrun}, 32'd0);
      check_eq("fc_empty", {31'h0, empty}, 32'd1);

      // Reset mid-sample has priority over wr and clken
      wsample(16'h2222);
      wbyte(8'h55);
      cyc(1, 1, 0, 8'h66, 1, 16'h1234);
      check_eq("rp_out", {16'h0, sound_out}, 32'h0);
      check_eq("rp_empty", {31'h0, empty}, 32'd1);
      wbyte(8'h77);
      wbyte(8'h88);
      pop(16'h0000);
      check_eq("rp_val", {16'h0, sound_out}, 32'h8877);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int          sel;
         logic [7:0]  d;
         logic [15:0] si;
         bit          ce;
         sel = int'($urandom_range(0, 99));
         d   = 8'($urandom);
         si  = 16'($urandom);
         ce  = ($urandom_range(0, 3) == 0);
         if (sel < 1) cyc(1, 0, 0, d, ce, si);
         else if (sel < 3) cyc(0, 1, 1, d & 8'h03, ce, si);
         else if (sel < 5) cyc(0, 1, 1, d & 8'hFC, ce, si);
         else if (sel < 60) cyc(0, 1, 0, d, ce, si);
         else cyc(0, 0, 0, d, ce, si);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
